mux9_scan_ctrl: RTL

//  Sequencer in front of and behind the 9:1 word mux. Drives the mux select and

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux9_scan_ctrl_if.sv | 13 +
 rtl/mux9_next_ch.sv | 31 +++
 rtl/mux9_scan_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the 9:1 word-mux scan sequencer.
package mux_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NUM_CH = 9;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/mux9_scan_ctrl_if.sv
// Captured-word output stream: tagged data with valid/ready handshake.
interface mux9_scan_ctrl_if;
    import mux_pkg::*;

    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_ch;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_ch, output out_valid, input out_ready);
    modport slave  (input out_data, input out_ch, input out_valid, output out_ready);

endinterface

// File: rtl/mux9_next_ch.sv
// Combinational channel search: lowest enabled channel and next enabled channel above cur.
module mux9_next_ch
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next_c,
    output logic              has_next_c,
    output logic [SEL_W-1:0]  low_c,
    output logic              any_c
);

    // Descending walk so the last hit is the lowest qualifying index.
    always_comb begin
        next_c     = '0;
        has_next_c = 1'b0;
        low_c      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_c = SEL_W'(i);
            end
            if (mask[i] && (SEL_W'(i) > cur)) begin
                next_c     = SEL_W'(i);
                has_next_c = 1'b1;
            end
        end
    end

    assign any_c = |mask;

endmodule

// File: rtl/mux9_scan_ctrl.sv
// Scan sequencer around a 9:1 word mux: steps sel over enabled channels and
// streams each captured word out tagged with its channel number.
module mux9_scan_ctrl
    import mux_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 continuous,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic [SEL_W-1:0]     sel,
    input  logic [WIDTH-1:0]     mux_y,
    output logic                 busy,
    output logic                 done,
    mux9_scan_ctrl_if.master     out_if
);

    state_t            state;
    logic [NUM_CH-1:0] mask_q;
    logic [WIDTH-1:0]  data_q;
    logic [SEL_W-1:0]  ch_q;
    logic              valid_q;

    logic [NUM_CH-1:0] search_mask_c;
    logic [SEL_W-1:0]  next_c;
    logic              has_next_c;
    logic [SEL_W-1:0]  low_c;
    logic              any_c;

    // In IDLE the incoming mask decides the first channel; afterwards only the latched copy counts.
    assign search_mask_c = (state == IDLE) ? ch_mask : mask_q;

    mux9_next_ch u_next_ch (
        .mask       (search_mask_c),
        .cur        (sel),
        .next_c     (next_c),
        .has_next_c (has_next_c),
        .low_c      (low_c),
        .any_c      (any_c)
    );

    assign out_if.out_data  = data_q;
    assign out_if.out_ch    = ch_q;
    assign out_if.out_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mask_q  <= '0;
            sel     <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                sel     <= '0;
                valid_q <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            mask_q <= ch_mask;
                            if (any_c) begin
                                sel   <= low_c;
                                busy  <= 1'b1;
                                state <= SELECT;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    SELECT: begin
                        data_q  <= mux_y;
                        ch_q    <= sel;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                    HOLD: begin
                        if (valid_q && out_if.out_ready) begin
                            valid_q <= 1'b0;
                            if (has_next_c) begin
                                sel   <= next_c;
                                state <= SELECT;
                            end else begin
                                done <= 1'b1;
                                if (continuous) begin
                                    sel   <= low_c;
                                    state <= SELECT;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
